// File: rtl/clk_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_gate_pkg
// Description : Shared types and constants for the clock-gate enable
//               controller: FSM state encoding, default intervals and the
//               interval-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_gate_pkg;

    // Controller states, 2-bit encoded
    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HOLD   = 2'd3
    } cg_state_t;

    localparam int DEF_WAKE_CYCLES = 2;
    localparam int DEF_IDLE_CYCLES = 4;

    // Width of a counter that has to reach an interval of 'cycles'
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cg_interval_cnt.sv
`default_nettype none
// ============================================================================
// Module      : cg_interval_cnt
// Description : Loadable interval up-counter with terminal-count compare.
//               Load clears to zero; increments stop at the terminal value
//               so the counter never wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module cg_interval_cnt
    import clk_gate_pkg::*;
#(
    parameter int TERMINAL = 2,
    parameter int WIDTH    = cnt_width(TERMINAL)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    output logic at_term
);

    localparam logic [WIDTH-1:0] c_term = WIDTH'(TERMINAL - 1);

    logic [WIDTH-1:0] r_count;
    logic             w_at_term;

    assign w_at_term = (r_count == c_term);
    assign at_term   = w_at_term;

    // Count register: cleared on state entry, held once terminal is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (inc && !w_at_term) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_gate_ctrl
// Description : Enable-side controller for a clock-gating cell. Wakes the
//               gated clock on request, waits a settle interval before
//               granting, and gates the clock again after an idle interval.
//               Optional macro CG_STATS_EN enables the gated-cycle counter
//               on gated_cycles (tied to zero otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    input  logic               test_en,
    output logic               clk_en,
    output logic               clk_on,
    output logic [CNT_W-1:0]   gated_cycles
);

    cg_state_t r_state;
    cg_state_t w_state_next;
    logic      r_en;
    logic      w_any_req;
    logic      w_wake_load;
    logic      w_wake_inc;
    logic      w_wake_done;
    logic      w_idle_load;
    logic      w_idle_inc;
    logic      w_idle_done;

    assign w_any_req = |req;

    cg_interval_cnt #(
        .TERMINAL (WAKE_CYCLES)
    ) u_wake_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_wake_load),
        .inc     (w_wake_inc),
        .at_term (w_wake_done)
    );

    cg_interval_cnt #(
        .TERMINAL (IDLE_CYCLES)
    ) u_idle_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_idle_load),
        .inc     (w_idle_inc),
        .at_term (w_idle_done)
    );

    // Next-state and counter control; a returning request beats HOLD expiry
    always_comb begin
        w_state_next = r_state;
        w_wake_load  = 1'b0;
        w_wake_inc   = 1'b0;
        w_idle_load  = 1'b0;
        w_idle_inc   = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (w_any_req) begin
                    w_state_next = ST_WAKE;
                    w_wake_load  = 1'b1;
                end
            end
            ST_WAKE: begin
                if (w_wake_done) begin
                    w_state_next = ST_ACTIVE;
                end else begin
                    w_wake_inc = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (!w_any_req) begin
                    w_state_next = ST_HOLD;
                    w_idle_load  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_any_req) begin
                    w_state_next = ST_ACTIVE;
                end else if (w_idle_done) begin
                    w_state_next = ST_OFF;
                end else begin
                    w_idle_inc = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_OFF;
            end
        endcase
    end

    // State register and glitch-free registered enable into the gate latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_en    <= (w_state_next != ST_OFF);
        end
    end

    assign clk_en = r_en | test_en;
    assign clk_on = (r_state == ST_ACTIVE) || (r_state == ST_HOLD);
    assign ack    = req & {NUM_REQ{r_state == ST_ACTIVE}};

`ifdef CG_STATS_EN
    logic [CNT_W-1:0] r_gated;

    // Saturating count of cycles spent with the clock gated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gated <= '0;
        end else if ((r_state == ST_OFF) && (r_gated != {CNT_W{1'b1}})) begin
            r_gated <= r_gated + CNT_W'(1);
        end
    end

    assign gated_cycles = r_gated;
`else
    assign gated_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_gate_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_gate_ctrl
// Description : Self-checking bench for clk_gate_ctrl: timer-based reference
//               model compared every cycle, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_gate_ctrl;

    localparam int NR   = 2;
    localparam int WAKE = 2;
    localparam int IDLE = 4;
    localparam int CW   = 16;
    localparam int GMAX = (1 << CW) - 1;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [NR-1:0] req     = '0;
    logic          test_en = 1'b0;
    logic [NR-1:0] ack;
    logic          clk_en;
    logic          clk_on;
    logic [CW-1:0] gated_cycles;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    clk_gate_ctrl #(
        .NUM_REQ     (NR),
        .WAKE_CYCLES (WAKE),
        .IDLE_CYCLES (IDLE),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .ack          (ack),
        .test_en      (test_en),
        .clk_en       (clk_en),
        .clk_on       (clk_on),
        .gated_cycles (gated_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the clock is either off, settling (edges left before
    // grant) or settled; once settled, count consecutive request-free edges.
    bit m_en;
    int m_wake_left;
    int m_idle_run;
    int m_gated;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en        <= 1'b0;
            m_wake_left <= 0;
            m_idle_run  <= 0;
            m_gated     <= 0;
        end else begin
            if (!m_en && m_gated < GMAX) m_gated <= m_gated + 1;
            if (!m_en) begin
                if (req != '0) begin
                    m_en        <= 1'b1;
                    m_wake_left <= WAKE;
                    m_idle_run  <= 0;
                end
            end else if (m_wake_left > 0) begin
                m_wake_left <= m_wake_left - 1;
            end else if (req != '0) begin
                m_idle_run <= 0;
            end else if (m_idle_run == IDLE) begin
                m_en       <= 1'b0;
                m_idle_run <= 0;
            end else begin
                m_idle_run <= m_idle_run + 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("clk_en", 32'(clk_en), 32'(m_en | test_en));
            chk("clk_on", 32'(clk_on), 32'(m_en && m_wake_left == 0));
            chk("ack", 32'(ack),
                32'(req & {NR{m_en && m_wake_left == 0 && m_idle_run == 0}}));
`ifdef CG_STATS_EN
            chk("gated_cycles", 32'(gated_cycles), 32'(m_gated));
`else
            chk("gated_cycles", 32'(gated_cycles), 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int run;
        run = 0;

        // Reset state
        #1;
        chk("rst_clk_en", 32'(clk_en), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_clk_on", 32'(clk_on), 32'd0);
        chk("rst_gated", 32'(gated_cycles), 32'd0);
        repeat (2) tick();
        rst_n  = 1'b1;
        cmp_on = 1'b1;
        tick();

        // Wake latency
        req = 2'b01;
        tick();
        chk("wake_e0_clk_en", 32'(clk_en), 32'd1);
        chk("wake_e0_ack", 32'(ack), 32'd0);
        tick();
        chk("wake_e1_ack", 32'(ack), 32'd0);
        tick();
        chk("wake_e2_ack", 32'(ack), 32'b01);
        chk("wake_e2_clk_on", 32'(clk_on), 32'd1);

        // Idle gating
        repeat (3) tick();
        req = 2'b00;
        #1;
        chk("idle_ack_drop", 32'(ack), 32'd0);
        tick();
        chk("idle_hold_clk_on", 32'(clk_on), 32'd1);
        repeat (3) tick();
        chk("idle_e3_clk_en", 32'(clk_en), 32'd1);
        tick();
        chk("idle_e4_clk_en", 32'(clk_en), 32'd0);
        chk("idle_e4_clk_on", 32'(clk_on), 32'd0);

        // HOLD rescue on the expiry edge
        req = 2'b10;
        repeat (3) tick();
        chk("rescue_grant", 32'(ack), 32'b10);
        tick();
        req = 2'b00;
        tick();
        repeat (3) tick();
        req = 2'b10;
        tick();
        chk("rescue_clk_en", 32'(clk_en), 32'd1);
        chk("rescue_clk_on", 32'(clk_on), 32'd1);
        chk("rescue_ack", 32'(ack), 32'b10);

        // Short pulse
        req = 2'b00;
        repeat (5) tick();
        chk("pulse_pre_off", 32'(clk_en), 32'd0);
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        tick();
        chk("pulse_active_clk_on", 32'(clk_on), 32'd1);
        chk("pulse_active_ack", 32'(ack), 32'd0);
        repeat (4) tick();
        chk("pulse_e6_clk_en", 32'(clk_en), 32'd1);
        tick();
        chk("pulse_e7_clk_en", 32'(clk_en), 32'd0);

        // Test override in OFF
        test_en = 1'b1;
        #1;
        chk("test_clk_en", 32'(clk_en), 32'd1);
        chk("test_ack", 32'(ack), 32'd0);
        repeat (3) tick();
        chk("test_clk_on", 32'(clk_on), 32'd0);
        test_en = 1'b0;

        // Reset mid-WAKE with requests held
        req = 2'b11;
        tick();
        rst_n = 1'b0;
        #1;
        chk("rstw_clk_en", 32'(clk_en), 32'd0);
        chk("rstw_ack", 32'(ack), 32'd0);
        chk("rstw_clk_on", 32'(clk_on), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rstw_rewake_clk_en", 32'(clk_en), 32'd1);
        chk("rstw_rewake_clk_on", 32'(clk_on), 32'd0);
        repeat (2) tick();
        chk("rstw_rewake_ack", 32'(ack), 32'b11);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if (run == 0) begin
                req = ($urandom_range(0, 2) == 0) ? '0 : NR'($urandom);
                run = $urandom_range(1, 9);
            end
            run--;
            test_en = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 249) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            tick();
        end
        test_en = 1'b0;

`ifdef CG_STATS_EN
        // Long gated stretch under test override: statistic saturates
        req = '0;
        test_en = 1'b1;
        repeat (65600) tick();
        chk("gated_saturate", 32'(gated_cycles), 32'hFFFF);
        test_en = 1'b0;
`endif

        req = '0;
        repeat (8) tick();
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
